// File: rtl/prog_counter.sv
// Programmable up/down modulo counter with prescaler, one-shot mode,
// terminal-count pulse, sticky overflow and compare output.
module prog_counter #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
`ifdef USE_POWER_PINS
  inout  wire                  vccd1,
  inout  wire                  vssd1,
`endif
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      max_val,
  input  logic [WIDTH-1:0]      cmp_val,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  mode,
  input  logic                  clr_ovf,
  output logic [WIDTH-1:0]      out,
  output logic                  tc,
  output logic                  cmp_match,
  output logic                  ovf,
  output logic                  running
);

  logic [PRESCALE_W-1:0] psc;
  logic                  active;
  logic                  tick;
  logic                  at_term;
  logic                  term_event;

  always_comb begin
    active     = enable && running;
    tick       = active && (psc == prescale);
    // Up terminal uses >= so a load above max_val ends on the next up tick.
    at_term    = up_down ? (out >= max_val) : (out == '0);
    term_event = tick && at_term;
  end

  assign cmp_match = (out == cmp_val);

  always_ff @(posedge clk) begin
    if (reset) begin
      out     <= '0;
      psc     <= '0;
      tc      <= 1'b0;
      ovf     <= 1'b0;
      running <= 1'b1;
    end else if (load) begin
      out     <= load_val;
      psc     <= '0;
      tc      <= 1'b0;
      running <= 1'b1;
      if (clr_ovf) ovf <= 1'b0;
    end else begin
      tc <= term_event;
      if (active) psc <= tick ? '0 : psc + 1'b1;
      if (tick) begin
        if (at_term) begin
          if (mode) running <= 1'b0;
          else      out     <= up_down ? '0 : max_val;
        end else begin
          out <= up_down ? out + 1'b1 : out - 1'b1;
        end
      end
      // Set wins over clear when both land on the same edge.
      if (term_event)   ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prog_counter.sv
// Directed-vector bench for prog_counter (WIDTH=8, PRESCALE_W=4).
module tb_prog_counter;

  logic       clk = 1'b0;
  logic       reset, enable, up_down, load, mode, clr_ovf;
  logic [7:0] load_val, max_val, cmp_val;
  logic [3:0] prescale;
  logic [7:0] out;
  logic       tc, cmp_match, ovf, running;

  int vectors = 0;
  int miscompares = 0;

  prog_counter #(.WIDTH(8), .PRESCALE_W(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
    .load(load), .load_val(load_val), .max_val(max_val), .cmp_val(cmp_val),
    .prescale(prescale), .mode(mode), .clr_ovf(clr_ovf),
    .out(out), .tc(tc), .cmp_match(cmp_match), .ovf(ovf), .running(running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int up_exp[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int dn_exp[5]  = '{2, 1, 0, 5, 4};

  initial begin
    reset = 1'b1; enable = 1'b0; up_down = 1'b1; load = 1'b0; mode = 1'b0;
    clr_ovf = 1'b0; load_val = 8'd0; max_val = 8'd9; cmp_val = 8'd0; prescale = 4'd0;

    // Reset state
    step();
    check("rst_out", out, 0);
    check("rst_tc", tc, 0);
    check("rst_ovf", ovf, 0);
    check("rst_running", running, 1);
    check("rst_cmp", cmp_match, 1);

    // Continuous up, max 9, prescale 0
    reset = 1'b0; enable = 1'b1; cmp_val = 8'd5;
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("up_out[%0d]", i), out, up_exp[i]);
      check($sformatf("up_tc[%0d]", i), tc, (i == 9) ? 1 : 0);
      check($sformatf("up_cmp[%0d]", i), cmp_match, (up_exp[i] == 5) ? 1 : 0);
    end
    check("up_ovf", ovf, 1);

    // clr_ovf alone clears; enable low holds out
    enable = 1'b0; clr_ovf = 1'b1;
    step();
    check("clr_ovf_alone", ovf, 0);
    check("hold_out", out, 2);
    clr_ovf = 1'b0;

    // Prescale 2: one tick per 3 enabled cycles
    reset = 1'b1; step(); reset = 1'b0;
    prescale = 4'd2; enable = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      check($sformatf("psc_out[%0d]", i), out, i / 3);
    end
    enable = 1'b0;
    step(); step();
    check("psc_hold", out, 3);

    // Down count from load 3, max 5; clr_ovf on the terminal edge
    reset = 1'b1; step(); reset = 1'b0;
    prescale = 4'd0; max_val = 8'd5; up_down = 1'b0;
    load = 1'b1; load_val = 8'd3;
    step();
    check("dn_load_out", out, 3);
    check("dn_load_tc", tc, 0);
    load = 1'b0; enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      clr_ovf = (i == 3);
      step();
      check($sformatf("dn_out[%0d]", i), out, dn_exp[i]);
      check($sformatf("dn_tc[%0d]", i), tc, (i == 3) ? 1 : 0);
    end
    clr_ovf = 1'b0;
    check("set_wins_ovf", ovf, 1);

    // Load on the edge of a would-be terminal tick
    load = 1'b1; load_val = 8'd0;
    step();
    check("ld0_out", out, 0);
    load_val = 8'd7;
    step();
    check("ld_term_out", out, 7);
    check("ld_term_tc", tc, 0);

    // Load above max: down decrements, up terminates
    load = 1'b0;
    step();
    check("above_dn_out", out, 6);
    up_down = 1'b1;
    step();
    check("above_up_out", out, 0);
    check("above_up_tc", tc, 1);

    // One-shot mode, max 4
    reset = 1'b1; step(); reset = 1'b0;
    mode = 1'b1; max_val = 8'd4; up_down = 1'b1; enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("os_out[%0d]", i), out, i);
      check($sformatf("os_tc[%0d]", i), tc, 0);
    end
    step();
    check("os_term_out", out, 4);
    check("os_term_tc", tc, 1);
    check("os_term_run", running, 0);
    step(); step();
    check("os_hold_out", out, 4);
    check("os_hold_tc", tc, 0);
    check("os_hold_run", running, 0);
    load = 1'b1; load_val = 8'd1;
    step();
    check("os_reload_out", out, 1);
    check("os_reload_run", running, 1);
    load = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      step();
      check($sformatf("os_resume[%0d]", i), out, i);
    end
    step();
    check("os_term2_tc", tc, 1);
    check("os_term2_run", running, 0);

    // Reset mid-count at out=7 with psc mid-period and a terminal pending
    mode = 1'b0; max_val = 8'd7; prescale = 4'd3;
    load = 1'b1; load_val = 8'd0;
    step();
    load = 1'b0;
    repeat (30) step();
    check("pre_rst_out", out, 7);
    check("pre_rst_ovf", ovf, 1);
    reset = 1'b1; cmp_val = 8'd0;
    step();
    check("mid_rst_out", out, 0);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_tc", tc, 0);
    check("mid_rst_run", running, 1);
    check("mid_rst_cmp", cmp_match, 1);
    reset = 1'b0;
    repeat (3) step();
    check("post_rst_psc3", out, 0);
    step();
    check("post_rst_psc4", out, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prog_counter.md
PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits (>=2).
REQ-002 Parameter PRESCALE_W, default 4, prescaler width in bits (>=1).
REQ-003 Power pins vccd1/vssd1 (inout) SHALL be present only under USE_POWER_PINS.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 enable  input  1  count enable; gates prescaler and counter.
REQ-007 up_down  input  1  1 = count up, 0 = count down.
REQ-008 load  input  1  synchronous load of load_val.
REQ-009 load_val  input  WIDTH  value written to out on load.
REQ-010 max_val  input  WIDTH  modulo limit; count range 0..max_val.
REQ-011 cmp_val  input  WIDTH  compare value.
REQ-012 prescale  input  PRESCALE_W  tick divider; tick every prescale+1 enabled cycles.
REQ-013 mode  input  1  0 = continuous (wrap), 1 = one-shot (stop at terminal).
REQ-014 clr_ovf  input  1  clears sticky ovf.
REQ-015 out  output  WIDTH  counter value (registered).
REQ-016 tc  output  1  terminal-count pulse (registered, one cycle).
REQ-017 cmp_match  output  1  high while out == cmp_val.
REQ-018 ovf  output  1  sticky terminal-count flag.
REQ-019 running  output  1  counter active; low after one-shot completion.

Function
REQ-020 Priority per edge SHALL be reset > load > tick-driven count.
REQ-021 Internal prescaler counter psc advances by 1 on each edge with enable=1 and running=1. When psc == prescale, a tick is generated, and psc returns to 0 on the same edge.
REQ-022 prescale=0 SHALL produce a tick on every enabled, running cycle.
REQ-023 With enable=0, psc and out SHALL hold.
REQ-024 Up tick: if out >= max_val, a terminal event occurs; otherwise out <= out+1.
REQ-025 Down tick: if out == 0, a terminal event occurs; otherwise out <= out-1.
REQ-026 Continuous-mode terminal event: out <= 0 (up) or out <= max_val (down).
REQ-027 One-shot-mode terminal event: out holds its value and running <= 0.
REQ-028 While running=0, no ticks SHALL occur and out SHALL hold, regardless of enable.
REQ-029 Every terminal event SHALL set tc=1 for exactly the following cycle; no terminal event SHALL leave tc=0.
REQ-030 Load SHALL set out <= load_val, psc <= 0 and running <= 1, and SHALL not assert tc.
REQ-031 Load values above max_val are accepted. The next up tick is then a terminal event. A down tick decrements normally.
REQ-032 ovf SHALL be set on each terminal event and cleared by clr_ovf; set SHALL win when both occur on the same edge.
REQ-033 cmp_match SHALL be a combinational compare of registered out with cmp_val, with no added latency.
REQ-034 Changing up_down, max_val or mode mid-count SHALL take effect on the next tick with no extra state.
REQ-035 Arithmetic is modulo 2^WIDTH; out SHALL never exceed 2^WIDTH-1.

Reset
REQ-036 On reset=1 at an edge: out=0, psc=0, tc=0, ovf=0, running=1, regardless of other inputs.
REQ-037 Reset mid-count SHALL discard any pending tick or terminal event.

Verification (WIDTH=8, PRESCALE_W=4)
REQ-038 up, max_val=9, prescale=0, mode=0, enable for 12 cycles -> out 1..9,0,1,2; tc high only in the cycle out first reads 0; ovf=1.
REQ-039 prescale=2, up, enable constant -> out increments once every 3 cycles; out=3 after 9 enabled cycles from reset.
REQ-040 down, max_val=5, load load_val=3, then enable -> out 3,2,1,0,5,4; tc high only in the cycle out reads 5.
REQ-041 mode=1, up, max_val=4, enable -> out 1,2,3,4 then holds; running=0; tc exactly once; then load load_val=1 -> running=1 and counting resumes 2,3,4.
REQ-042 load=1 on the same edge as a would-be terminal tick -> out=load_val, tc=0. clr_ovf on the same edge as a terminal event -> ovf stays 1; clr_ovf alone -> ovf=0.
REQ-043 reset asserted at out=7 with psc mid-period -> next cycle out=0, ovf=0, tc=0, running=1; cmp_val=0 gives cmp_match=1.
